// File: rtl/reg_file.sv
// 32 x DATA_WIDTH register file for the single-cycle RISC-V datapath: two combinational
// read ports, one write port, x0 hardwired to zero, x10 (a0) exported. Macro REGFILE_BYPASS_EN enables write-first forwarding.
module reg_file #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] AD1,
    input  logic [ADDRESS_WIDTH-1:0] AD2,
    input  logic [ADDRESS_WIDTH-1:0] AD3,
    input  logic                     WE3,
    input  logic [DATA_WIDTH-1:0]    WD3,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    output logic [DATA_WIDTH-1:0]    a0
);

    localparam int                     DEPTH  = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);

    logic [DATA_WIDTH-1:0] r_regs [0:DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (WE3 && (AD3 != '0)) begin
            r_regs[AD3] <= WD3;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // A live write forwards WD3 to any port reading the same register; x0 and reset never forward.
    logic w_wr_live;
    assign w_wr_live = WE3 && (AD3 != '0) && !rst;

    assign RD1 = (AD1 == '0)                 ? '0  :
                 (w_wr_live && (AD1 == AD3)) ? WD3 : r_regs[AD1];
    assign RD2 = (AD2 == '0)                 ? '0  :
                 (w_wr_live && (AD2 == AD3)) ? WD3 : r_regs[AD2];
    assign a0  = (w_wr_live && (AD3 == A0_IDX)) ? WD3 : r_regs[A0_IDX];
`else
    assign RD1 = (AD1 == '0) ? '0 : r_regs[AD1];
    assign RD2 = (AD2 == '0) ? '0 : r_regs[AD2];
    assign a0  = r_regs[A0_IDX];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: vector table for read/write/x0/a0 behaviour plus
// hand-written sequences for asynchronous reset and reset-versus-write priority.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  AD1, AD2, AD3;
    logic        WE3;
    logic [31:0] WD3;
    logic [31:0] RD1, RD2, a0;

    int n_pass  = 0;
    int n_total = 0;

    reg_file #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .AD1(AD1), .AD2(AD2), .AD3(AD3),
        .WE3(WE3), .WD3(WD3),
        .RD1(RD1), .RD2(RD2), .a0(a0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  ad3;
        logic [31:0] wd;
        logic [4:0]  ad1;
        logic [4:0]  ad2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_a0;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    initial begin
        // Each vector: drive after negedge, check pre-edge outputs, write commits at the next posedge.
        vecs[0]  = '{1'b1, 5'd7,  32'h1234_5678, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  32'h1234_5678, 32'h1234_5678, 32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd7,  5'd0,  32'h1234_5678, 32'h0, 32'h0};
        vecs[3]  = '{1'b1, 5'd10, 32'h0000_00FF, 5'd0,  5'd7,  32'h0, 32'h1234_5678, BYP ? 32'hFF : 32'h0};
        vecs[4]  = '{1'b1, 5'd11, 32'hCAFE_F00D, 5'd10, 5'd11, 32'hFF, BYP ? 32'hCAFE_F00D : 32'h0, 32'hFF};
        vecs[5]  = '{1'b1, 5'd3,  32'h1,         5'd11, 5'd10, 32'hCAFE_F00D, 32'hFF, 32'hFF};
        vecs[6]  = '{1'b1, 5'd3,  32'h2,         5'd3,  5'd3,  BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, 32'hFF};
        vecs[7]  = '{1'b0, 5'd3,  32'h55,        5'd3,  5'd11, 32'h2, 32'hCAFE_F00D, 32'hFF};
        vecs[8]  = '{1'b1, 5'd31, 32'h8000_0001, 5'd31, 5'd0,  BYP ? 32'h8000_0001 : 32'h0, 32'h0, 32'hFF};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd3,  32'h8000_0001, 32'h2, 32'hFF};
        vecs[10] = '{1'b1, 5'd0,  32'hAAAA_AAAA, 5'd0,  5'd0,  32'h0, 32'h0, 32'hFF};
        vecs[11] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd10, 32'h0, 32'hFF, 32'hFF};

        rst = 1'b1; WE3 = 1'b0; AD1 = 5'd7; AD2 = 5'd10; AD3 = 5'd0; WD3 = 32'h0;
        #2;
        check("reset_rd1", RD1, 32'h0);
        check("reset_rd2", RD2, 32'h0);
        check("reset_a0",  a0,  32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            WE3 = vecs[i].we; AD3 = vecs[i].ad3; WD3 = vecs[i].wd;
            AD1 = vecs[i].ad1; AD2 = vecs[i].ad2;
            #1;
            check($sformatf("vec%0d_rd1", i), RD1, vecs[i].e_rd1);
            check($sformatf("vec%0d_rd2", i), RD2, vecs[i].e_rd2);
            check($sformatf("vec%0d_a0",  i), a0,  vecs[i].e_a0);
        end

        // Same-cycle write to x3 is committed by the edge in both modes.
        @(negedge clk);
        WE3 = 1'b0; AD1 = 5'd3; AD2 = 5'd7;
        #1;
        check("x3_after_edge", RD1, 32'h2);

        // Preload x5, then assert reset between edges: state must clear with no clock.
        @(negedge clk);
        WE3 = 1'b1; AD3 = 5'd5; WD3 = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        WE3 = 1'b0; AD1 = 5'd5;
        #1;
        check("x5_preload", RD1, 32'hDEAD_BEEF);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_rd1", RD1, 32'h0);
        check("async_rst_a0",  a0,  32'h0);
        check("async_rst_rd2", RD2, 32'h0);

        // Write attempted while reset is held: blocked, and not forwarded.
        @(negedge clk);
        WE3 = 1'b1; AD3 = 5'd4; WD3 = 32'hA5A5_A5A5; AD1 = 5'd4;
        #1;
        check("rst_no_bypass", RD1, 32'h0);
        @(posedge clk); #1;
        check("rst_blocks_write", RD1, 32'h0);
        @(negedge clk);
        WE3 = 1'b0; rst = 1'b0;
        #1;
        check("x4_after_rst", RD1, 32'h0);

        // First write after reset release lands on the first rising edge.
        @(negedge clk);
        WE3 = 1'b1; AD3 = 5'd4; WD3 = 32'h0000_0077;
        @(posedge clk); #1;
        WE3 = 1'b0;
        check("first_write_post_rst", RD1, 32'h0000_0077);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
